// File: rtl/kd_search_ctrl.sv
// Nearest-center search sequencer for a heap-indexed kd-tree of centers.
// Descends root->leaf along the CE's first_direction, then backtracks via a node stack.
module kd_search_ctrl #(
  parameter int unsigned Dim       = 3,
  parameter int unsigned DataRange = 255,
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataW     = Dim * $clog2(DataRange + 1),
  parameter int unsigned MemLat    = 1,
  parameter int unsigned CeLat     = 1,
  localparam int unsigned AxisW    = (Dim > 1) ? $clog2(Dim) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pt_valid_i,
  output logic             pt_ready_o,
  input  logic [DataW-1:0] pt_data_i,
  output logic             node_rd_o,
  output logic [Depth-1:0] node_addr_o,
  input  logic [DataW-1:0] node_data_i,
  output logic             ce_en_o,
  output logic             ce_point_prop_o,
  output logic             ce_returned_o,
  output logic [AxisW-1:0] ce_axis_o,
  output logic [DataW-1:0] ce_left_o,
  output logic [DataW-1:0] ce_parent_o,
  output logic [DataW-1:0] ce_right_o,
  input  logic             ce_first_direction_i,
  input  logic             ce_other_branch_i,
  input  logic [DataW-1:0] ce_new_parent_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [Depth-1:0] res_idx_o,
  output logic [DataW-1:0] res_data_o,
  output logic             busy_o
);

  localparam int unsigned LvlW   = $clog2(Depth);
  localparam int unsigned StkN   = Depth - 1;
  localparam int unsigned CntMax = (MemLat > CeLat) ? MemLat : CeLat;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StEval, StPop, StDone} state_e;

  typedef struct packed {
    logic [Depth-1:0] idx;
    logic             dir;
    logic             done;
  } entry_t;

  state_e           state_q, state_d;
  logic [Depth-1:0] cur_q, cur_d, best_idx_q, best_idx_d;
  logic [LvlW-1:0]  level_q, level_d, sp_q, sp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             first_q, first_d, ret_q, ret_d, dir_q, dir_d;
  logic [DataW-1:0] point_q, point_d, node_q, node_d, best_q, best_d;
  entry_t           stk_q [StkN];
  entry_t           push_entry, top;
  logic             push;

  logic             pt_ready_q, busy_q, node_rd_q, ce_en_q, ce_ret_q, res_valid_q;
  logic [Depth-1:0] node_addr_q, res_idx_q;
  logic [AxisW-1:0] ce_axis_q;
  logic [DataW-1:0] ce_left_q, ce_parent_q, ce_right_q, res_data_q;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    best_idx_d = best_idx_q;
    level_d    = level_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    ret_d      = ret_q;
    dir_d      = dir_q;
    point_d    = point_q;
    node_d     = node_q;
    best_d     = best_q;
    push       = 1'b0;
    push_entry = '0;
    top        = (sp_q != '0) ? stk_q[sp_q - 1'b1] : '0;

    unique case (state_q)
      StIdle: begin
        if (pt_valid_i) begin
          point_d    = pt_data_i;
          cur_d      = Depth'(1);
          level_d    = '0;
          first_d    = 1'b1;
          ret_d      = 1'b0;
          best_d     = '0;
          best_idx_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(MemLat - 1)) begin
          node_d  = node_data_i;
          cnt_d   = '0;
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEval: begin
        if (cnt_q == CntW'(CeLat)) begin
          cnt_d = '0;
          if (!ret_q) begin
            if (first_q) begin
              best_d     = node_q;
              best_idx_d = Depth'(1);
              first_d    = 1'b0;
            end else begin
              best_d = ce_new_parent_i;
              if (ce_new_parent_i == node_q) best_idx_d = cur_q;
            end
            if (cur_q[Depth-1]) begin
              state_d = StPop;
            end else begin
              push       = 1'b1;
              push_entry = '{idx: cur_q, dir: ce_first_direction_i, done: 1'b0};
              // dir=1 selects the left child (2*cur)
              cur_d      = {cur_q[Depth-2:0], ~ce_first_direction_i};
              level_d    = level_q + 1'b1;
              state_d    = StFetch;
            end
          end else if (ce_other_branch_i) begin
            push       = 1'b1;
            push_entry = '{idx: cur_q, dir: dir_q, done: 1'b1};
            cur_d      = {cur_q[Depth-2:0], dir_q};
            level_d    = level_q + 1'b1;
            ret_d      = 1'b0;
            state_d    = StFetch;
          end else begin
            state_d = StPop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPop: begin
        if (sp_q == '0) begin
          state_d = StDone;
        end else begin
          sp_d = sp_q - 1'b1;
          if (!top.done) begin
            cur_d   = top.idx;
            dir_d   = top.dir;
            // an entry's stack slot equals its tree level
            level_d = sp_q - 1'b1;
            ret_d   = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (push) sp_d = sp_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      best_idx_q  <= '0;
      level_q     <= '0;
      sp_q        <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      ret_q       <= 1'b0;
      dir_q       <= 1'b0;
      point_q     <= '0;
      node_q      <= '0;
      best_q      <= '0;
      for (int i = 0; i < StkN; i++) stk_q[i] <= '0;
      pt_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      node_rd_q   <= 1'b0;
      node_addr_q <= '0;
      ce_en_q     <= 1'b0;
      ce_ret_q    <= 1'b0;
      ce_axis_q   <= '0;
      ce_left_q   <= '0;
      ce_parent_q <= '0;
      ce_right_q  <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      best_idx_q <= best_idx_d;
      level_q    <= level_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      ret_q      <= ret_d;
      dir_q      <= dir_d;
      point_q    <= point_d;
      node_q     <= node_d;
      best_q     <= best_d;
      if (push) stk_q[sp_q] <= push_entry;
      // Outputs are registered from the next state so they align with state_q.
      pt_ready_q  <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      node_rd_q   <= (state_d == StFetch);
      node_addr_q <= (state_d == StFetch) ? cur_d : '0;
      ce_en_q     <= (state_d == StEval);
      ce_ret_q    <= (state_d == StEval) && ret_d;
      ce_axis_q   <= (state_d == StEval) ? AxisW'(32'(level_d) % Dim) : '0;
      ce_left_q   <= (state_d == StEval) ? node_d : '0;
      ce_parent_q <= (state_d == StEval) ? point_d : '0;
      ce_right_q  <= (state_d == StEval) ? best_d : '0;
      res_valid_q <= (state_d == StDone);
      res_idx_q   <= (state_d == StDone) ? best_idx_d : '0;
      res_data_q  <= (state_d == StDone) ? best_d : '0;
    end
  end

  assign pt_ready_o      = pt_ready_q;
  assign busy_o          = busy_q;
  assign node_rd_o       = node_rd_q;
  assign node_addr_o     = node_addr_q;
  assign ce_en_o         = ce_en_q;
  assign ce_point_prop_o = ce_en_q;
  assign ce_returned_o   = ce_ret_q;
  assign ce_axis_o       = ce_axis_q;
  assign ce_left_o       = ce_left_q;
  assign ce_parent_o     = ce_parent_q;
  assign ce_right_o      = ce_right_q;
  assign res_valid_o     = res_valid_q;
  assign res_idx_o       = res_idx_q;
  assign res_data_o      = res_data_q;

endmodule

// File: tb/tb_kd_search_ctrl.sv
// Bench for kd_search_ctrl: node memory model, stub CE, fetch/result scoreboards.
module tb_kd_search_ctrl;

  localparam int unsigned Dim       = 3;
  localparam int unsigned DataRange = 255;
  localparam int unsigned Depth     = 4;
  localparam int unsigned DataW     = 24;
  localparam int unsigned MemLat    = 1;
  localparam int unsigned CeLat     = 1;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             pt_valid_i = 1'b0;
  logic             pt_ready_o;
  logic [DataW-1:0] pt_data_i = '0;
  logic             node_rd_o;
  logic [Depth-1:0] node_addr_o;
  logic [DataW-1:0] node_data_i;
  logic             ce_en_o, ce_point_prop_o, ce_returned_o;
  logic [1:0]       ce_axis_o;
  logic [DataW-1:0] ce_left_o, ce_parent_o, ce_right_o;
  logic             ce_first_direction_i, ce_other_branch_i;
  logic [DataW-1:0] ce_new_parent_i;
  logic             res_valid_o;
  logic             res_ready_i = 1'b0;
  logic [Depth-1:0] res_idx_o;
  logic [DataW-1:0] res_data_o;
  logic             busy_o;

  kd_search_ctrl #(
    .Dim(Dim), .DataRange(DataRange), .Depth(Depth), .DataW(DataW),
    .MemLat(MemLat), .CeLat(CeLat)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i),
    .node_rd_o(node_rd_o), .node_addr_o(node_addr_o), .node_data_i(node_data_i),
    .ce_en_o(ce_en_o), .ce_point_prop_o(ce_point_prop_o), .ce_returned_o(ce_returned_o),
    .ce_axis_o(ce_axis_o), .ce_left_o(ce_left_o), .ce_parent_o(ce_parent_o),
    .ce_right_o(ce_right_o), .ce_first_direction_i(ce_first_direction_i),
    .ce_other_branch_i(ce_other_branch_i), .ce_new_parent_i(ce_new_parent_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_idx_o(res_idx_o),
    .res_data_o(res_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [Depth-1:0] idx;
    logic [DataW-1:0] data;
  } res_t;

  typedef struct {
    int               addr;
    logic [1:0]       axis;
    logic             ret;
    logic [DataW-1:0] parent;
  } eval_t;

  logic [DataW-1:0] mem [1 << Depth];
  int    checks = 0;
  int    failures = 0;
  int    exp_addr_q[$];
  int    obs_addr_q[$];
  res_t  exp_res_q[$];
  eval_t obs_eval_q[$];
  bit    mon_en = 1'b0;
  bit    prev_en = 1'b0;
  int    last_addr = 0;
  bit    stub_dir = 1'b1;
  bit    stub_np_left = 1'b0;
  int    stub_other_node = 0;

  // Stub CE: fixed direction, optional explore at one node, new_parent = left or right.
  always_comb begin
    ce_first_direction_i = stub_dir;
    ce_other_branch_i    = ce_returned_o && (last_addr == stub_other_node);
    ce_new_parent_i      = stub_np_left ? ce_left_o : ce_right_o;
  end

  // Node memory (MemLat=1) and fetch/eval observers.
  initial begin
    node_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (node_rd_o) begin
        last_addr   = int'(node_addr_o);
        node_data_i = mem[node_addr_o];
        if (mon_en) obs_addr_q.push_back(last_addr);
      end
      if (ce_en_o && !prev_en && mon_en) begin
        eval_t ev;
        ev.addr = last_addr; ev.axis = ce_axis_o; ev.ret = ce_returned_o; ev.parent = ce_parent_o;
        obs_eval_q.push_back(ev);
      end
      prev_en = ce_en_o;
    end
  end

  task automatic run_search(input logic [DataW-1:0] pt, output int cyc, output bit ok);
    obs_addr_q.delete();
    obs_eval_q.delete();
    mon_en     = 1'b1;
    pt_data_i  = pt;
    pt_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    pt_valid_i = 1'b0;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (res_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic release_result();
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (pt_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_pt_ready got=%b want=1", pt_ready_o);
    end
    checks++;
    if ({busy_o, node_rd_o, ce_en_o, ce_point_prop_o, ce_returned_o, res_valid_o} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=000000",
        {busy_o, node_rd_o, ce_en_o, ce_point_prop_o, ce_returned_o, res_valid_o});
    end
    checks++;
    if ({node_addr_o, ce_axis_o, res_idx_o} !== 10'b0) begin
      failures++; $display("FAIL reset_idx got=%h want=0", {node_addr_o, ce_axis_o, res_idx_o});
    end
    checks++;
    if ({ce_left_o, ce_parent_o, ce_right_o, res_data_o} !== '0) begin
      failures++; $display("FAIL reset_buses got=%h want=0",
        {ce_left_o, ce_parent_o, ce_right_o, res_data_o});
    end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_basic_timing();
    int cyc; bit ok; res_t e;
    stub_dir = 1'b1; stub_np_left = 1'b0; stub_other_node = 0;
    exp_addr_q = '{1, 2, 4, 8, 4, 2, 1};
    e.idx = 4'd1; e.data = mem[1]; exp_res_q.push_back(e);
    run_search(24'h102030, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done timeout after %0d cycles", cyc); end
    else begin
      e = exp_res_q.pop_front();
      checks++;
      if (cyc + 1 != 33) begin failures++; $display("FAIL basic_latency got=%0d want=33", cyc + 1); end
      checks++;
      if (res_idx_o !== e.idx) begin failures++; $display("FAIL basic_idx got=%0d want=%0d", res_idx_o, e.idx); end
      checks++;
      if (res_data_o !== e.data) begin failures++; $display("FAIL basic_data got=%h want=%h", res_data_o, e.data); end
      release_result();
    end
    checks++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      failures++; $display("FAIL basic_nfetch got=%0d want=%0d", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] != exp_addr_q[i]) begin
        failures++; $display("FAIL basic_fetch[%0d] got=%0d want=%0d", i, obs_addr_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_best_leaf(input string name);
    int cyc; bit ok; res_t e;
    stub_dir = 1'b1; stub_np_left = 1'b1; stub_other_node = 0;
    exp_addr_q = '{1, 2, 4, 8, 4, 2, 1};
    e.idx = 4'd8; e.data = mem[8]; exp_res_q.push_back(e);
    run_search(24'h44aa11, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_done timeout", name); end
    else begin
      e = exp_res_q.pop_front();
      checks++;
      if (res_idx_o !== e.idx) begin failures++; $display("FAIL %s_idx got=%0d want=%0d", name, res_idx_o, e.idx); end
      checks++;
      if (res_data_o !== e.data) begin failures++; $display("FAIL %s_data got=%h want=%h", name, res_data_o, e.data); end
      release_result();
    end
    checks++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      failures++; $display("FAIL %s_nfetch got=%0d want=%0d", name, obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] != exp_addr_q[i]) begin
        failures++; $display("FAIL %s_fetch[%0d] got=%0d want=%0d", name, i, obs_addr_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_other_branch();
    int cyc; bit ok; res_t e; int lvl; int a;
    bit exp_ret [8] = '{0, 0, 0, 0, 1, 0, 1, 1};
    logic [DataW-1:0] pt = 24'h778899;
    stub_dir = 1'b1; stub_np_left = 1'b1; stub_other_node = 4;
    exp_addr_q = '{1, 2, 4, 8, 4, 9, 2, 1};
    e.idx = 4'd9; e.data = mem[9]; exp_res_q.push_back(e);
    run_search(pt, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL other_done timeout"); end
    else begin
      e = exp_res_q.pop_front();
      checks++;
      if ({res_idx_o, res_data_o} !== {e.idx, e.data}) begin
        failures++; $display("FAIL other_result got=%0d/%h want=%0d/%h", res_idx_o, res_data_o, e.idx, e.data);
      end
      release_result();
    end
    checks++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      failures++; $display("FAIL other_nfetch got=%0d want=%0d", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] != exp_addr_q[i]) begin
        failures++; $display("FAIL other_fetch[%0d] got=%0d want=%0d", i, obs_addr_q[i], exp_addr_q[i]);
      end
    end
    for (int i = 0; i < 8 && i < obs_eval_q.size(); i++) begin
      a = exp_addr_q[i]; lvl = 0;
      while (a > 1) begin a = a >> 1; lvl++; end
      checks++;
      if ({obs_eval_q[i].ret, obs_eval_q[i].axis, obs_eval_q[i].parent} !== {exp_ret[i], 2'(lvl % 3), pt}) begin
        failures++; $display("FAIL other_eval[%0d] got ret=%b axis=%0d parent=%h want ret=%b axis=%0d parent=%h",
          i, obs_eval_q[i].ret, obs_eval_q[i].axis, obs_eval_q[i].parent, exp_ret[i], lvl % 3, pt);
      end
    end
  endtask

  task automatic test_right_descent();
    int cyc; bit ok; res_t e;
    stub_dir = 1'b0; stub_np_left = 1'b0; stub_other_node = 0;
    exp_addr_q = '{1, 3, 7, 15, 7, 3, 1};
    e.idx = 4'd1; e.data = mem[1]; exp_res_q.push_back(e);
    run_search(24'h0f0e0d, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL right_done timeout"); end
    else begin
      e = exp_res_q.pop_front();
      checks++;
      if ({res_idx_o, res_data_o} !== {e.idx, e.data}) begin
        failures++; $display("FAIL right_result got=%0d/%h want=%0d/%h", res_idx_o, res_data_o, e.idx, e.data);
      end
      release_result();
    end
    checks++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      failures++; $display("FAIL right_nfetch got=%0d want=%0d", obs_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      checks++;
      if (obs_addr_q[i] != exp_addr_q[i]) begin
        failures++; $display("FAIL right_fetch[%0d] got=%0d want=%0d", i, obs_addr_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_eval();
    bit found = 1'b0;
    stub_dir = 1'b1; stub_np_left = 1'b1; stub_other_node = 0;
    mon_en = 1'b0;
    pt_data_i = 24'h123456; pt_valid_i = 1'b1;
    @(posedge clk_i);
    #1 pt_valid_i = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk_i);
      #1 found = ce_en_o;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rstmid_eval got=no_eval want=eval"); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({pt_ready_o, busy_o, node_rd_o, ce_en_o, ce_point_prop_o, ce_returned_o, res_valid_o} !== 7'b1000000) begin
      failures++; $display("FAIL rstmid_ctrl got=%b want=1000000",
        {pt_ready_o, busy_o, node_rd_o, ce_en_o, ce_point_prop_o, ce_returned_o, res_valid_o});
    end
    checks++;
    if ({node_addr_o, ce_axis_o, res_idx_o, ce_left_o, ce_parent_o, ce_right_o, res_data_o} !== '0) begin
      failures++; $display("FAIL rstmid_buses got=%h want=0",
        {node_addr_o, ce_axis_o, res_idx_o, ce_left_o, ce_parent_o, ce_right_o, res_data_o});
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    test_best_leaf("rstmid");
  endtask

  task automatic test_hold_result();
    int cyc; bit ok; res_t e;
    stub_dir = 1'b1; stub_np_left = 1'b0; stub_other_node = 0;
    exp_addr_q = '{1, 2, 4, 8, 4, 2, 1};
    e.idx = 4'd1; e.data = mem[1]; exp_res_q.push_back(e);
    run_search(24'h665544, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hold_done timeout"); end
    else begin
      e = exp_res_q.pop_front();
      pt_data_i = 24'hdeadbe; pt_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk_i);
        #1;
        checks++;
        if ({res_valid_o, pt_ready_o, busy_o, res_idx_o, res_data_o} !== {3'b101, e.idx, e.data}) begin
          failures++; $display("FAIL hold_stable[%0d] got v=%b rdy=%b busy=%b idx=%0d data=%h want v=1 rdy=0 busy=1 idx=%0d data=%h",
            i, res_valid_o, pt_ready_o, busy_o, res_idx_o, res_data_o, e.idx, e.data);
        end
      end
      pt_valid_i = 1'b0;
      release_result();
      checks++;
      if ({pt_ready_o, busy_o, res_valid_o} !== 3'b100) begin
        failures++; $display("FAIL hold_release got=%b want=100", {pt_ready_o, busy_o, res_valid_o});
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL hold_no_accept busy got=%b want=0", busy_o); end
    end
    checks++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      failures++; $display("FAIL hold_nfetch got=%0d want=%0d", obs_addr_q.size(), exp_addr_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << Depth); i++) mem[i] = {8'(i * 37 + 11), 8'(i * 13 + 5), 8'(200 - i)};
    test_reset();
    test_basic_timing();
    test_best_leaf("leaf");
    test_other_branch();
    test_right_descent();
    test_reset_mid_eval();
    test_hold_result();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
